// File: rtl/accel_exec_pkg.sv
// Shared definitions for the tile-based execution units: tile geometry,
// ReLU sequencer states and tile-count arithmetic.
package accel_exec_pkg;

    localparam int unsigned TILE_ELEMS = 32;

    typedef enum logic [1:0] {
        IDLE       = 2'd0,
        WAIT_READ  = 2'd1,
        ISSUE_READ = 2'd2,
        COMPLETE   = 2'd3
    } relu_state_t;

    // Ceiling divide of an element count by the tile size, 11 bits so 1023 -> 32 fits.
    function automatic logic [10:0] tiles_for_len(input logic [9:0] len);
        logic [10:0] l;
        l = {1'b0, len};
        return (l + 11'(TILE_ELEMS - 1)) / 11'(TILE_ELEMS);
    endfunction

endpackage

// File: rtl/relu_tile.sv
// Combinational per-lane ReLU with tail masking; lanes at or beyond
// valid_lanes are forced to zero (valid_lanes == 0 means a full tile).
module relu_tile
    import accel_exec_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = 8,
    parameter int unsigned LANES      = TILE_ELEMS
) (
    input  logic [LANES-1:0][DATA_WIDTH-1:0] tile_in,
    input  logic [5:0]                       valid_lanes,
    output logic [LANES-1:0][DATA_WIDTH-1:0] tile_out
);

    logic [6:0] limit;

    always_comb begin
        tile_out = '0;
        limit    = (valid_lanes == '0) ? 7'(LANES) : {1'b0, valid_lanes};
        for (int unsigned i = 0; i < LANES; i++) begin
            if ((7'(i) < limit) && !tile_in[i][DATA_WIDTH-1]) begin
                tile_out[i] = tile_in[i];
            end
        end
    end

endmodule

// File: rtl/relu_execution.sv
// Element-wise ReLU execution unit: streams tiles from a source buffer,
// clamps negatives to zero and writes each tile to a destination buffer.
module relu_execution
    import accel_exec_pkg::*;
#(
    parameter  int unsigned DATA_WIDTH = 8,
    parameter  int unsigned TILE_WIDTH = 256,
    localparam int unsigned ELEMS      = TILE_WIDTH / DATA_WIDTH
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic                             start,
    input  logic [4:0]                       src_buffer_id,
    input  logic [4:0]                       dest_buffer_id,
    input  logic [9:0]                       length,
    output logic                             busy,
    output logic                             done,
    output logic                             vec_read_enable,
    output logic [4:0]                       vec_read_buffer_id,
    input  logic [ELEMS-1:0][DATA_WIDTH-1:0] vec_read_tile,
    input  logic                             vec_read_valid,
    output logic                             vec_write_enable,
    output logic [4:0]                       vec_write_buffer_id,
    output logic [ELEMS-1:0][DATA_WIDTH-1:0] vec_write_tile
);

    relu_state_t state_q, state_d;
    logic [9:0]  length_q, length_d;
    logic [10:0] total_q, total_d;
    logic [10:0] count_q, count_d;
    logic        rd_en_q, rd_en_d;
    logic        wr_en_q, wr_en_d;
    logic        done_q, done_d;
    logic        busy_q, busy_d;
    logic [4:0]  rd_id_q, rd_id_d;
    logic [4:0]  wr_id_q, wr_id_d;
    logic [ELEMS-1:0][DATA_WIDTH-1:0] wtile_q, wtile_d;

    logic [15:0] remain;
    logic [5:0]  valid_lanes;
    logic [ELEMS-1:0][DATA_WIDTH-1:0] relu_out;

    // Elements still owed for the current tile; only the last tile can be partial.
    always_comb begin
        remain      = {6'b0, length_q} - (16'(count_q) * 16'(ELEMS));
        valid_lanes = (remain >= 16'(ELEMS)) ? 6'd0 : remain[5:0];
    end

    relu_tile #(
        .DATA_WIDTH (DATA_WIDTH),
        .LANES      (ELEMS)
    ) u_relu_tile (
        .tile_in     (vec_read_tile),
        .valid_lanes (valid_lanes),
        .tile_out    (relu_out)
    );

    always_comb begin
        state_d  = state_q;
        length_d = length_q;
        total_d  = total_q;
        count_d  = count_q;
        rd_id_d  = rd_id_q;
        wr_id_d  = wr_id_q;
        wtile_d  = wtile_q;
        rd_en_d  = 1'b0;
        wr_en_d  = 1'b0;
        done_d   = 1'b0;
        case (state_q)
            IDLE: begin
                if (start) begin
                    length_d = length;
                    rd_id_d  = src_buffer_id;
                    wr_id_d  = dest_buffer_id;
                    total_d  = tiles_for_len(length);
                    count_d  = '0;
                    if (length == '0) begin
                        state_d = COMPLETE;
                    end else begin
                        rd_en_d = 1'b1;
                        state_d = WAIT_READ;
                    end
                end
            end
            WAIT_READ: begin
                if (vec_read_valid) begin
                    wtile_d = relu_out;
                    wr_en_d = 1'b1;
                    count_d = count_q + 11'd1;
                    state_d = (count_q + 11'd1 == total_q) ? COMPLETE : ISSUE_READ;
                end
            end
            ISSUE_READ: begin
                rd_en_d = 1'b1;
                state_d = WAIT_READ;
            end
            COMPLETE: begin
                done_d  = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q  <= IDLE;
            length_q <= '0;
            total_q  <= '0;
            count_q  <= '0;
            rd_en_q  <= 1'b0;
            wr_en_q  <= 1'b0;
            done_q   <= 1'b0;
            busy_q   <= 1'b0;
            rd_id_q  <= '0;
            wr_id_q  <= '0;
            wtile_q  <= '0;
        end else begin
            state_q  <= state_d;
            length_q <= length_d;
            total_q  <= total_d;
            count_q  <= count_d;
            rd_en_q  <= rd_en_d;
            wr_en_q  <= wr_en_d;
            done_q   <= done_d;
            busy_q   <= busy_d;
            rd_id_q  <= rd_id_d;
            wr_id_q  <= wr_id_d;
            wtile_q  <= wtile_d;
        end
    end

    assign busy                = busy_q;
    assign done                = done_q;
    assign vec_read_enable     = rd_en_q;
    assign vec_read_buffer_id  = rd_id_q;
    assign vec_write_enable    = wr_en_q;
    assign vec_write_buffer_id = wr_id_q;
    assign vec_write_tile      = wtile_q;

endmodule

// File: tb/tb_relu_execution.sv
// Directed bench for relu_execution: table of whole-vector transactions
// plus hand-written zero-length, reset-abort and restart sequences.
module tb_relu_execution;

    logic             clk;
    logic             rst;
    logic             start;
    logic [4:0]       src;
    logic [4:0]       dst;
    logic [9:0]       len;
    logic             busy;
    logic             done;
    logic             re;
    logic [4:0]       rd_id;
    logic [31:0][7:0] rtile;
    logic             vld;
    logic             we;
    logic [4:0]       wr_id;
    logic [31:0][7:0] wtile;

    int checks = 0;
    int errors = 0;
    int rd_cnt = 0;
    int wr_cnt = 0;
    int done_cnt = 0;

    relu_execution #(
        .DATA_WIDTH (8),
        .TILE_WIDTH (256)
    ) dut (
        .clk                 (clk),
        .rst                 (rst),
        .start               (start),
        .src_buffer_id       (src),
        .dest_buffer_id      (dst),
        .length              (len),
        .busy                (busy),
        .done                (done),
        .vec_read_enable     (re),
        .vec_read_buffer_id  (rd_id),
        .vec_read_tile       (rtile),
        .vec_read_valid      (vld),
        .vec_write_enable    (we),
        .vec_write_buffer_id (wr_id),
        .vec_write_tile      (wtile)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(negedge clk) begin
        rd_cnt   += int'(re);
        wr_cnt   += int'(we);
        done_cnt += int'(done);
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    typedef struct {
        int       len;
        logic [4:0] src;
        logic [4:0] dst;
        int       lat0;
        int       latn;
        int       kind;
        int       exp_tiles;
        bit       poke;
    } vec_t;

    vec_t vecs[7];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [7:0] pat(input int kind, input int t, input int i);
        case (kind)
            0:       return (t == 0) ? 8'hFB : 8'(i - 16);
            1:       return (i % 2 == 0) ? 8'h80 : 8'h7F;
            2:       return 8'(i * 7 + t * 13 - 100);
            3:       return 8'(i - t - 3);
            default: return 8'(50 - i + t);
        endcase
    endfunction

    function automatic logic [7:0] exp_lane(input int kind, input int t, input int i, input int ln);
        logic signed [7:0] v;
        v = pat(kind, t, i);
        if (t * 32 + i >= ln) return 8'h00;
        if (v < 0) return 8'h00;
        return v;
    endfunction

    task automatic run_txn(input vec_t v);
        int r0, w0, d0, lat;
        logic [255:0] e;
        r0 = rd_cnt; w0 = wr_cnt; d0 = done_cnt;
        len = 10'(v.len); src = v.src; dst = v.dst; start = 1'b1;
        tick();
        start = 1'b0;
        chk("busy_after_start", busy, 1);
        for (int t = 0; t < v.exp_tiles; t++) begin
            chk("read_strobe", re, 1);
            chk("read_id", rd_id, v.src);
            lat = (t == 0) ? v.lat0 : v.latn;
            for (int c = 1; c < lat; c++) begin
                if (v.poke && t == 0 && c == 1) begin
                    start = 1'b1; len = 10'd5; src = 5'd17; dst = 5'd18;
                end
                tick();
                start = 1'b0;
                chk("no_early_write", we, 0);
            end
            for (int i = 0; i < 32; i++) rtile[i] = pat(v.kind, t, i);
            vld = 1'b1;
            tick();
            vld = 1'b0;
            rtile = '1;
            for (int i = 0; i < 32; i++) e[i*8 +: 8] = exp_lane(v.kind, t, i, v.len);
            chk("write_strobe", we, 1);
            chk("write_id", wr_id, v.dst);
            chk("write_tile", wtile, e);
            chk("busy_during", busy, 1);
            chk("done_early", done, 0);
            tick();
        end
        chk("done_pulse", done, 1);
        chk("busy_at_done", busy, 0);
        tick();
        chk("done_one_cycle", done, 0);
        chk("read_count", rd_cnt - r0, v.exp_tiles);
        chk("write_count", wr_cnt - w0, v.exp_tiles);
        chk("done_count", done_cnt - d0, 1);
    endtask

    initial begin
        int r0, w0, d0;
        //           len   src    dst    lat0 latn kind tiles poke
        vecs[0] = '{  40, 5'd1,  5'd2,  3,   3,   0,   2,   0};
        vecs[1] = '{  32, 5'd4,  5'd5,  1,   1,   1,   1,   0};
        vecs[2] = '{  64, 5'd3,  5'd3,  2,   2,   2,   2,   1};
        vecs[3] = '{  33, 5'd6,  5'd7,  1,  10,   4,   2,   0};
        vecs[4] = '{1023, 5'd8,  5'd9,  1,   1,   2,  32,   0};
        vecs[5] = '{  31, 5'd10, 5'd11, 4,   1,   3,   1,   0};
        vecs[6] = '{ 256, 5'd31, 5'd0,  1,   2,   4,   8,   0};

        rst = 1'b0; start = 1'b0; src = '0; dst = '0; len = '0; vld = 1'b0; rtile = '0;
        repeat (3) tick();
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_re", re, 0);
        chk("rst_we", we, 0);
        chk("rst_rd_id", rd_id, 0);
        chk("rst_wr_id", wr_id, 0);
        chk("rst_tile", wtile, 0);
        rst = 1'b1;
        tick();

        for (int n = 0; n < 7; n++) run_txn(vecs[n]);

        // Zero length: done two cycles after start, no buffer traffic.
        r0 = rd_cnt; w0 = wr_cnt; d0 = done_cnt;
        len = 10'd0; src = 5'd20; dst = 5'd21; start = 1'b1;
        tick();
        start = 1'b0;
        chk("zl_busy", busy, 1);
        chk("zl_done_early", done, 0);
        chk("zl_rd_id", rd_id, 20);
        chk("zl_wr_id", wr_id, 21);
        tick();
        chk("zl_done", done, 1);
        chk("zl_busy_end", busy, 0);
        tick();
        chk("zl_reads", rd_cnt - r0, 0);
        chk("zl_writes", wr_cnt - w0, 0);
        chk("zl_dones", done_cnt - d0, 1);

        // Reset while waiting on the second tile of a 96-element run.
        len = 10'd96; src = 5'd12; dst = 5'd13; start = 1'b1;
        tick();
        start = 1'b0;
        for (int i = 0; i < 32; i++) rtile[i] = pat(2, 0, i);
        vld = 1'b1;
        tick();
        vld = 1'b0;
        chk("ab_write0", we, 1);
        tick();
        chk("ab_read1", re, 1);
        tick();
        rst = 1'b0;
        tick();
        rst = 1'b1;
        chk("ab_busy", busy, 0);
        chk("ab_done", done, 0);
        chk("ab_re", re, 0);
        chk("ab_we", we, 0);
        chk("ab_rd_id", rd_id, 0);
        chk("ab_wr_id", wr_id, 0);
        chk("ab_tile", wtile, 0);
        r0 = rd_cnt; w0 = wr_cnt; d0 = done_cnt;
        vld = 1'b1;
        tick();
        vld = 1'b0;
        chk("ab_late_valid_we", we, 0);
        chk("ab_late_valid_busy", busy, 0);
        tick();
        tick();
        chk("ab_reads", rd_cnt - r0, 0);
        chk("ab_writes", wr_cnt - w0, 0);
        chk("ab_dones", done_cnt - d0, 0);
        run_txn(vecs[0]);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
